// File: rtl/boron_round_ctrl_if.sv
// Host-side block handshake for the Boron round controller: block in with
// start/ready, ciphertext out with valid/ack.
interface boron_round_ctrl_if #(
  parameter int DW = 64
);
  logic          start_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ack_i;

  modport master (
    output start_i, data_i, ack_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  start_i, data_i, ack_i,
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/boron_round_ctrl.sv
// Round sequencer for an iterated Boron block cipher. It owns the state register
// and the round index; the round function and key schedule are external.
//
// state | meaning
// IDLE  | ready for a new block, round index 0
// LOAD  | one cycle, strobes the key schedule to load the master key
// RUN   | ROUNDS cycles, state <= external round result, key schedule steps
// FINAL | one cycle, final key whitening, round index = ROUNDS
// DONE  | ciphertext valid and held until ack
module boron_round_ctrl #(
  parameter int ROUNDS = 25,
  parameter int DW     = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  boron_round_ctrl_if.slave host,
  output logic [DW-1:0] round_data_o,
  input  logic [DW-1:0] round_data_i,
  input  logic [DW-1:0] rkey_i,
  output logic [4:0]    round_idx_o,
  output logic          key_load_o,
  output logic          key_step_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX  = 5'(ROUNDS - 1);
  localparam logic [4:0] FINAL_IDX = 5'(ROUNDS);

  state_t        state_q, state_d;
  logic [DW-1:0] blk_q, blk_d;
  logic [4:0]    idx_q, idx_d;
  logic          ready_q, valid_q, key_load_q, key_step_q;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (host.start_i) begin
          blk_d   = host.data_i;
          idx_d   = 5'd0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        blk_d = round_data_i;
        if (idx_q == LAST_IDX) begin
          idx_d   = FINAL_IDX;
          state_d = FINAL;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      FINAL: begin
        blk_d   = blk_q ^ rkey_i;
        state_d = DONE;
      end
      DONE: begin
        if (host.ack_i) begin
          idx_d   = 5'd0;
          state_d = IDLE;
        end
      end
      default: begin
        blk_d   = '0;
        idx_d   = 5'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      idx_q      <= 5'd0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      key_load_q <= 1'b0;
      key_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      ready_q    <= (state_d == IDLE);
      valid_q    <= (state_d == DONE);
      key_load_q <= (state_d == LOAD);
      key_step_q <= (state_d == RUN);
    end
  end

  assign host.ready_o = ready_q;
  assign host.valid_o = valid_q;
  assign host.data_o  = blk_q;
  assign round_data_o = blk_q;
  assign round_idx_o  = idx_q;
  assign key_load_o   = key_load_q;
  assign key_step_o   = key_step_q;

endmodule

// File: tb/tb_boron_round_ctrl.sv
// Directed bench for boron_round_ctrl: default, ROUNDS=1 and ROUNDS=30 instances
// with an increment stub as round datapath and an all-ones round key.
module tb_boron_round_ctrl;
  localparam int DW = 64;
  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  boron_round_ctrl_if #(.DW(DW)) h25 ();
  boron_round_ctrl_if #(.DW(DW)) h1 ();
  boron_round_ctrl_if #(.DW(DW)) h30 ();

  logic [DW-1:0] rd_o25, rd_o1, rd_o30;
  logic [4:0]    idx25, idx1, idx30;
  logic          kl25, kl1, kl30, ks25, ks1, ks30;

  boron_round_ctrl #(.ROUNDS(25), .DW(DW)) u25 (
    .clk_i(clk), .rst_i(rst), .host(h25.slave),
    .round_data_o(rd_o25), .round_data_i(rd_o25 + 64'd1), .rkey_i(ONES),
    .round_idx_o(idx25), .key_load_o(kl25), .key_step_o(ks25)
  );
  boron_round_ctrl #(.ROUNDS(1), .DW(DW)) u1 (
    .clk_i(clk), .rst_i(rst), .host(h1.slave),
    .round_data_o(rd_o1), .round_data_i(rd_o1 + 64'd1), .rkey_i(ONES),
    .round_idx_o(idx1), .key_load_o(kl1), .key_step_o(ks1)
  );
  boron_round_ctrl #(.ROUNDS(30), .DW(DW)) u30 (
    .clk_i(clk), .rst_i(rst), .host(h30.slave),
    .round_data_o(rd_o30), .round_data_i(rd_o30 + 64'd1), .rkey_i(ONES),
    .round_idx_o(idx30), .key_load_o(kl30), .key_step_o(ks30)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset25(input string tag);
    chk({tag, ".ready"}, 64'(h25.ready_o), 64'd1);
    chk({tag, ".valid"}, 64'(h25.valid_o), 64'd0);
    chk({tag, ".data"},  h25.data_o, 64'd0);
    chk({tag, ".idx"},   64'(idx25), 64'd0);
    chk({tag, ".kload"}, 64'(kl25), 64'd0);
    chk({tag, ".kstep"}, 64'(ks25), 64'd0);
  endtask

  logic [DW-1:0] held;
  int n;

  initial begin
    h25.start_i = 0; h25.data_i = '0; h25.ack_i = 0;
    h1.start_i  = 0; h1.data_i  = '0; h1.ack_i  = 0;
    h30.start_i = 0; h30.data_i = '0; h30.ack_i = 0;
    #12;
    chk_reset25("reset");
    tick();
    rst = 1'b0;
    tick();

    // Single block with start held and data changing throughout (busy rejection)
    h25.start_i = 1; h25.data_i = 64'h0123_4567_89AB_CDEF;
    h25.ack_i = 1;  // ack outside DONE must be ignored
    tick();
    chk("load.kload", 64'(kl25), 64'd1);
    chk("load.kstep", 64'(ks25), 64'd0);
    chk("load.ready", 64'(h25.ready_o), 64'd0);
    chk("load.idx",   64'(idx25), 64'd0);
    for (int k = 0; k < 25; k++) begin
      h25.data_i = 64'hDEAD_0000_0000_0000 + 64'(k);
      tick();
      chk("run.kstep", 64'(ks25), 64'd1);
      chk("run.kload", 64'(kl25), 64'd0);
      chk("run.idx",   64'(idx25), 64'(k));
      chk("run.ready", 64'(h25.ready_o), 64'd0);
    end
    h25.ack_i = 0;
    tick();
    chk("final.idx",   64'(idx25), 64'd25);
    chk("final.kstep", 64'(ks25), 64'd0);
    chk("final.valid", 64'(h25.valid_o), 64'd0);
    tick();
    chk("done.valid", 64'(h25.valid_o), 64'd1);
    chk("done.data",  h25.data_o, 64'hFEDC_BA98_7654_31F7);
    chk("done.ready", 64'(h25.ready_o), 64'd0);
    h25.start_i = 0;

    // Backpressure: hold ack low for 10 cycles
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp.valid", 64'(h25.valid_o), 64'd1);
      chk("bp.data",  h25.data_o, 64'hFEDC_BA98_7654_31F7);
    end
    h25.ack_i = 1;
    tick();
    h25.ack_i = 0;
    chk("ack.ready", 64'(h25.ready_o), 64'd1);
    chk("ack.valid", 64'(h25.valid_o), 64'd0);
    chk("ack.idx",   64'(idx25), 64'd0);

    // Reset in the middle of RUN at round index 12
    h25.start_i = 1; h25.data_i = 64'h1111_2222_3333_4444;
    tick();
    h25.start_i = 0;
    for (int k = 0; k < 13; k++) tick();
    chk("mid.idx", 64'(idx25), 64'd12);
    #1 rst = 1'b1;
    #1;
    chk_reset25("midrst");
    tick();
    rst = 1'b0;
    tick();
    chk("postrst.valid", 64'(h25.valid_o), 64'd0);

    // Fresh block after the abort: latency and result
    h25.start_i = 1; h25.data_i = 64'h0;
    n = 0;
    tick();
    h25.start_i = 0;
    n = 1;
    while (!h25.valid_o && n < 100) begin
      tick();
      n++;
    end
    chk("rerun.latency", 64'(n), 64'd28);
    chk("rerun.data", h25.data_o, 64'hFFFF_FFFF_FFFF_FFE6);

    // Back-to-back: start together with ack is not taken until the next IDLE cycle
    h25.ack_i = 1; h25.start_i = 1; h25.data_i = 64'h1000;
    tick();
    h25.ack_i = 0;
    chk("b2b.idle_ready", 64'(h25.ready_o), 64'd1);
    chk("b2b.idle_kload", 64'(kl25), 64'd0);
    tick();
    h25.start_i = 0;
    chk("b2b.load_kload", 64'(kl25), 64'd1);
    for (int k = 0; k < 27; k++) tick();
    chk("b2b.valid", 64'(h25.valid_o), 64'd1);
    held = h25.data_o;
    chk("b2b.data", held, 64'hFFFF_FFFF_FFFF_EFE6);
    h25.ack_i = 1;
    tick();
    h25.ack_i = 0;

    // ROUNDS=1: one RUN cycle, valid at T+4
    h1.start_i = 1; h1.data_i = 64'h5;
    tick();
    h1.start_i = 0;
    chk("r1.kload", 64'(kl1), 64'd1);
    tick();
    chk("r1.kstep", 64'(ks1), 64'd1);
    chk("r1.idx0",  64'(idx1), 64'd0);
    tick();
    chk("r1.final_idx", 64'(idx1), 64'd1);
    chk("r1.final_kstep", 64'(ks1), 64'd0);
    tick();
    chk("r1.valid", 64'(h1.valid_o), 64'd1);
    chk("r1.data",  h1.data_o, 64'hFFFF_FFFF_FFFF_FFF9);

    // ROUNDS=30: index reaches 30 in FINAL without wrapping
    h30.start_i = 1; h30.data_i = 64'h0;
    tick();
    h30.start_i = 0;
    for (int k = 0; k < 30; k++) tick();
    chk("r30.last_idx", 64'(idx30), 64'd29);
    tick();
    chk("r30.final_idx", 64'(idx30), 64'd30);
    tick();
    chk("r30.valid", 64'(h30.valid_o), 64'd1);
    chk("r30.data",  h30.data_o, 64'hFFFF_FFFF_FFFF_FFE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
